moore_seq_detector: RTL and testbench
=====================================

# moore_seq_detector

Parametrised Moore sequence detector: the generalised successor of the lab's fixed three-state Moore FSM. It recognises a compile-time bit pattern of configurable length on a serial input. Overlapping or non-overlapping matching is selectable, input sampling is gated by an enable, and matches are counted in a saturating counter. It sits behind a serial bit source, such as a synchroniser or deserialiser, and drives a registered match flag and a match counter to downstream control logic.

## Interface
- LEN, 4, pattern length in bits; legal range 2..16
- PATTERN, 4'b1011, LEN-bit pattern; PATTERN[LEN-1] is the first bit received
- OVERLAP, 1, 1 = overlapping matches, 0 = non-overlapping
- CNT_W, 8, match counter width; legal range 1..32
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  sample strobe; x is consumed only on edges where en=1
- x  input  1  serial data bit
- clr_cnt  input  1  synchronous clear of match_cnt and sat
- y  output  1  Moore match flag, decoded from state only
- match_cnt  output  CNT_W  saturating count of matches
- sat  output  1  high while match_cnt equals 2^CNT_W-1
- state_o  output  $clog2(LEN+1)  current state index, for debug

## Operation
- States S0..S_LEN. Sk means the last k sampled bits equal the first k pattern bits, i.e. PATTERN[LEN-1 -: k].
- y = (state == S_LEN), and nothing else; x must never reach y combinationally.
- Next state when en=1 and the current state is Sk with k<LEN:
  - if x == PATTERN[LEN-1-k], go to Sk+1;
  - otherwise go to the longest j<=k such that the last j bits of (matched prefix, x) equal the first j pattern bits (KMP failure function).
- Failure table: computed at elaboration from PATTERN (function or generate). No runtime search.
- From S_LEN with en=1:
  - OVERLAP=1: treat the current state as S_f, where f = failure(LEN) is the longest proper border of PATTERN, then apply the rule above.
  - OVERLAP=0: treat the current state as S0, then apply the rule above.
- en=0: state holds and y holds.
- Counter: increments on every edge where en=1 and next state is S_LEN. It saturates at 2^CNT_W-1 and never wraps.
- sat: registered; set when match_cnt reaches its maximum.
- clr_cnt=1: match_cnt<=0 and sat<=0. Clear wins over a simultaneous increment. State and y are unaffected.
- Unreachable state encodings recover to S0 on the next edge, with y=0.

## Timing
- Reset (async assert, state held while rst=1): state=S0, y=0, match_cnt=0, sat=0, state_o=0.
- Release: first sample is taken on the first rising edge after rst deasserts.
- Latency: the last pattern bit is sampled at edge t; y=1 and match_cnt updated are both visible after edge t (one register stage). y stays high until the next edge with en=1.
- Reset asserted mid-sequence discards partial progress. After release, a pattern needs all LEN bits again.
- Back-to-back matches with OVERLAP=1 and a border of length f: y can reassert LEN-f samples later.

## Test plan
- Reset: drive 1,0,1 (state_o=3), assert rst between edges -> state_o=0 and y=0 immediately, without waiting for a clock edge; after release, 1 -> state_o=1.
- Overlap, defaults (PATTERN=1011): x = 1,0,1,1,0,1,1 with en=1 -> y high after the 4th and 7th samples, match_cnt=2.
- Non-overlap (OVERLAP=0): same stream -> y high only after the 4th sample; final state_o=1; match_cnt=1.
- KMP fallback: x = 1,0,1,0,1,1 -> state_o sequence 1,2,3,2,3,4; y high after the 6th sample only.
- Enable gating: stream 1,0,1,1 with en=0 inserted for 3 cycles between the 2nd and 3rd bits -> state_o holds at 2 during the gap; a single match follows.
- Counter edges, CNT_W=2: 5 matches -> match_cnt=3 and sat=1 after the 3rd match. Then clr_cnt=1 on the same edge as a 6th match -> match_cnt=0, sat=0, y=1.

Source files
------------

// File: rtl/moore_seq_detector.sv
// Parametrised Moore sequence detector with KMP fallback, enable gating and a
// saturating match counter. Transition table is built at elaboration.
module moore_seq_detector #(
  parameter int unsigned      LEN     = 4,
  parameter logic [LEN-1:0]   PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        x,
  input  logic                        clr_cnt,
  output logic                        y,
  output logic [CNT_W-1:0]            match_cnt,
  output logic                        sat,
  output logic [$clog2(LEN+1)-1:0]    state_o
);

  localparam int unsigned SW     = $clog2(LEN + 1);
  localparam int unsigned NSTATE = 1 << SW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef logic [SW-1:0] state_t;

  // p-th pattern bit in arrival order (p = 0 is the first bit received)
  function automatic logic pat_bit(input int unsigned p);
    logic [LEN-1:0] t;
    t = PATTERN >> (LEN - 1 - p);
    return t[0];
  endfunction

  // Longest j <= k+1 such that the last j bits of (prefix_k, xb) equal prefix_j
  function automatic int unsigned calc_next(input int unsigned k, input logic xb);
    logic [16:0]  s;
    logic         ok;
    int unsigned  best;
    s    = '0;
    best = 0;
    for (int unsigned p = 0; p < k; p++) s = s | (17'(pat_bit(p)) << p);
    s = s | (17'(xb) << k);
    for (int unsigned j = 1; j <= k + 1; j++) begin
      ok = 1'b1;
      for (int unsigned q = 0; q < j; q++) begin
        if (1'(s >> (k + 1 - j + q)) != pat_bit(q)) ok = 1'b0;
      end
      if (ok) best = j;
    end
    return best;
  endfunction

  // Longest proper border of the whole pattern
  function automatic int unsigned calc_border();
    logic        ok;
    int unsigned best;
    best = 0;
    for (int unsigned j = 1; j < LEN; j++) begin
      ok = 1'b1;
      for (int unsigned q = 0; q < j; q++) begin
        if (pat_bit(LEN - j + q) != pat_bit(q)) ok = 1'b0;
      end
      if (ok) best = j;
    end
    return best;
  endfunction

  localparam int unsigned BORDER  = calc_border();
  localparam int unsigned RESTART = OVERLAP ? BORDER : 0;

  // Next-state table indexed by current state; unreachable encodings map to S0
  state_t nxt0 [NSTATE];
  state_t nxt1 [NSTATE];

  for (genvar k = 0; k < NSTATE; k++) begin : g_tab
    localparam bit          VALID = (k <= LEN);
    localparam int unsigned EFF   = (k == LEN) ? RESTART : k;
    assign nxt0[k] = VALID ? SW'(calc_next(EFF, 1'b0)) : '0;
    assign nxt1[k] = VALID ? SW'(calc_next(EFF, 1'b1)) : '0;
  end

  state_t           state_q, state_d;
  logic             y_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q;
  logic             inc;

  always_comb begin
    state_d = state_q;
    inc     = 1'b0;
    cnt_d   = cnt_q;
    if (state_q > SW'(LEN)) begin
      state_d = '0;
    end else if (en) begin
      state_d = x ? nxt1[state_q] : nxt0[state_q];
    end
    inc = en && (state_d == SW'(LEN));
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      y_q     <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= (state_d == SW'(LEN));
      cnt_q   <= cnt_d;
      sat_q   <= (cnt_d == CNT_MAX);
    end
  end

  assign y         = y_q;
  assign match_cnt = cnt_q;
  assign sat       = sat_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Scoreboarded bench for moore_seq_detector: four configurations share one
// stimulus stream and are checked against a history-based reference model.
module tb_moore_seq_detector;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic x = 1'b0;
  logic clr_cnt = 1'b0;

  always #5 clk = ~clk;

  logic       y_a, y_b, y_c, y_d;
  logic       sat_a, sat_b, sat_c, sat_d;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic [2:0] cnt_d;
  logic [2:0] st_a, st_b, st_c, st_d;

  moore_seq_detector #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt),
    .y(y_a), .match_cnt(cnt_a), .sat(sat_a), .state_o(st_a));
  moore_seq_detector #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt),
    .y(y_b), .match_cnt(cnt_b), .sat(sat_b), .state_o(st_b));
  moore_seq_detector #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt),
    .y(y_c), .match_cnt(cnt_c), .sat(sat_c), .state_o(st_c));
  moore_seq_detector #(.LEN(6), .PATTERN(6'b110110), .OVERLAP(1'b1), .CNT_W(3)) u_d (
    .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt),
    .y(y_d), .match_cnt(cnt_d), .sat(sat_d), .state_o(st_d));

  int a_st [N];
  int a_y  [N];
  int a_cnt[N];
  int a_sat[N];

  always_comb begin
    a_st[0] = int'(st_a);  a_y[0] = int'(y_a);  a_cnt[0] = int'(cnt_a); a_sat[0] = int'(sat_a);
    a_st[1] = int'(st_b);  a_y[1] = int'(y_b);  a_cnt[1] = int'(cnt_b); a_sat[1] = int'(sat_b);
    a_st[2] = int'(st_c);  a_y[2] = int'(y_c);  a_cnt[2] = int'(cnt_c); a_sat[2] = int'(sat_c);
    a_st[3] = int'(st_d);  a_y[3] = int'(y_d);  a_cnt[3] = int'(cnt_d); a_sat[3] = int'(sat_d);
  end

  // Reference model: per instance, the sampled bit history since the last
  // reset (or since the last consumed match when matches may not overlap).
  int          m_len[N] = '{4, 4, 4, 6};
  logic [15:0] m_pat[N] = '{16'h000B, 16'h000B, 16'h000B, 16'h0036};
  bit          m_ovl[N] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int          m_max[N] = '{255, 255, 3, 7};
  logic [31:0] h_v[N];
  int          h_n[N];
  int          m_st[N];
  int          m_cnt[N];

  typedef struct {
    int idx;
    int st;
    int y;
    int cnt;
    int sat;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Longest suffix of the history that equals a prefix of the pattern
  function automatic int longest(input int i);
    int  kmax, res;
    bit  ok, found;
    kmax  = (h_n[i] < m_len[i]) ? h_n[i] : m_len[i];
    res   = 0;
    found = 1'b0;
    for (int k = kmax; k >= 0; k--) begin
      if (!found) begin
        ok = 1'b1;
        for (int q = 0; q < k; q++) begin
          if (1'(h_v[i] >> (k - 1 - q)) != 1'(m_pat[i] >> (m_len[i] - 1 - q))) ok = 1'b0;
        end
        if (ok) begin
          res   = k;
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      h_v[i] = '0; h_n[i] = 0; m_st[i] = 0; m_cnt[i] = 0;
    end
  endfunction

  function automatic void model_step(input logic e, input logic xv, input logic c);
    for (int i = 0; i < N; i++) begin
      if (e) begin
        if (!m_ovl[i] && m_st[i] == m_len[i]) h_n[i] = 0;
        h_v[i] = {h_v[i][30:0], xv};
        if (h_n[i] < 32) h_n[i]++;
        m_st[i] = longest(i);
      end
      if (c) m_cnt[i] = 0;
      else if (e && m_st[i] == m_len[i] && m_cnt[i] < m_max[i]) m_cnt[i]++;
      sb.push_back('{i, m_st[i], int'(m_st[i] == m_len[i]), m_cnt[i],
                     int'(m_cnt[i] == m_max[i])});
    end
  endfunction

  // Monitor: outputs are valid every cycle, checked on the falling edge
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("u%0d.state", e.idx), a_st[e.idx],  e.st);
      chk($sformatf("u%0d.y", e.idx),     a_y[e.idx],   e.y);
      chk($sformatf("u%0d.cnt", e.idx),   a_cnt[e.idx], e.cnt);
      chk($sformatf("u%0d.sat", e.idx),   a_sat[e.idx], e.sat);
    end
  end

  task automatic step(input logic e, input logic xv, input logic c);
    en = e; x = xv; clr_cnt = c;
    @(posedge clk);
    model_step(e, xv, c);
    #1;
  endtask

  // Async reset asserted between edges, after the scoreboard has drained
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d.rst_state", i), a_st[i], 0);
      chk($sformatf("u%0d.rst_y", i), a_y[i], 0);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic s2[7];
    logic s3[6];
    int   e3[6];

    s2 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    s3 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    e3 = '{1, 2, 3, 2, 3, 4};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d.por_state", i), a_st[i], 0);
      chk($sformatf("u%0d.por_y", i), a_y[i], 0);
      chk($sformatf("u%0d.por_cnt", i), a_cnt[i], 0);
      chk($sformatf("u%0d.por_sat", i), a_sat[i], 0);
    end
    rst = 1'b0;

    // Reset mid-sequence discards progress
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);
    chk("midseq_state", a_st[0], 3);
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    chk("post_release_state", a_st[0], 1);

    // Overlap vs non-overlap on 1011011
    do_reset();
    for (int k = 0; k < 7; k++) begin
      step(1'b1, s2[k], 1'b0);
      if (k == 3) begin
        chk("ovl_y4", a_y[0], 1);
        chk("novl_y4", a_y[1], 1);
      end
    end
    chk("ovl_y7", a_y[0], 1);
    chk("ovl_cnt", a_cnt[0], 2);
    chk("novl_y7", a_y[1], 0);
    chk("novl_state", a_st[1], 1);
    chk("novl_cnt", a_cnt[1], 1);

    // KMP fallback on 101011
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(1'b1, s3[k], 1'b0);
      chk($sformatf("kmp_state%0d", k), a_st[0], e3[k]);
      chk($sformatf("kmp_y%0d", k), a_y[0], (k == 5) ? 1 : 0);
    end

    // Enable gap between the 2nd and 3rd bits
    do_reset();
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      chk($sformatf("gap_state%0d", k), a_st[0], 2);
    end
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    chk("gap_y", a_y[0], 1);
    chk("gap_cnt", a_cnt[0], 1);

    // Saturation on the 2-bit counter, then clear colliding with a match
    do_reset();
    for (int m = 1; m <= 5; m++) begin
      step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
      if (m == 2) chk("sat_pre", a_sat[2], 0);
      if (m == 3) begin
        chk("cnt_at3", a_cnt[2], 3);
        chk("sat_at3", a_sat[2], 1);
      end
    end
    chk("cnt_at5", a_cnt[2], 3);
    chk("sat_at5", a_sat[2], 1);
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b1);
    chk("clr_cnt", a_cnt[2], 0);
    chk("clr_sat", a_sat[2], 0);
    chk("clr_y", a_y[2], 1);
    chk("clr_cnt_a", a_cnt[0], 0);

    // Randomised run against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 59) == 0);
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
